debounce_scheduler: RTL and testbench

- Services up to NUM_BUTTONS raw mechanical inputs with one shared debounce countdown timer, instead of one timer per input.
- Rising edges are synchronized and queued as pending requests. A round-robin arbiter grants one channel at a time.
- Each grant emits a one-cycle debounced pulse for that channel, then blanks for DEBOUNCE_LENGTH+1 cycles.
- Sits between board pushbuttons and the user-interface control logic.

---
 rtl/debounce_scheduler.sv | 172 +++++++++++++++++
 tb/tb_debounce_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_scheduler.sv
// Shared-timer debounce scheduler: synchronizes raw buttons, queues rising edges and grants them round-robin.
// Optional macro DEBOUNCE_SCHEDULER_RELEASE_WAIT_EN holds the blanking state until the granted button is released.
module debounce_scheduler #(
    parameter int unsigned        NUM_BUTTONS     = 4,
    parameter int unsigned        CNT_W           = 22,
    parameter logic [CNT_W-1:0]   DEBOUNCE_LENGTH = 22'd2500000
) (
    input  logic                           CLK,
    input  logic                           Reset,
    input  logic [NUM_BUTTONS-1:0]         Button_In,
    output logic [NUM_BUTTONS-1:0]         Button_Pulse,
    output logic [$clog2(NUM_BUTTONS)-1:0] Grant_Index,
    output logic                           Busy,
    output logic [NUM_BUTTONS-1:0]         Pending
);

    localparam int unsigned            IDX_W    = $clog2(NUM_BUTTONS);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_BUTTONS - 1);
    localparam logic [NUM_BUTTONS-1:0] ONE_HOT0 = {{(NUM_BUTTONS-1){1'b0}}, 1'b1};
    localparam logic [NUM_BUTTONS-1:0] ZERO_VEC = {NUM_BUTTONS{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t                   r_state;
    logic [NUM_BUTTONS-1:0]   r_s1;
    logic [NUM_BUTTONS-1:0]   r_s2;
    logic [NUM_BUTTONS-1:0]   r_s3;
    logic [NUM_BUTTONS-1:0]   r_pending;
    logic [NUM_BUTTONS-1:0]   r_pulse;
    logic [IDX_W-1:0]         r_grant_idx;
    logic [IDX_W-1:0]         r_last_grant;
    logic                     r_busy;
    logic [CNT_W-1:0]         r_cnt;

    logic [NUM_BUTTONS-1:0]   w_edge;
    logic [NUM_BUTTONS-1:0]   w_lock;
    logic [NUM_BUTTONS-1:0]   w_grant_mask;
    logic [IDX_W-1:0]         w_sel_idx;
    logic [IDX_W-1:0]         w_cand;
    logic                     w_sel_found;
    logic                     w_hit;
    logic                     w_release_ok;

    // Two-flop synchronizer plus one history flop for rising-edge detection.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_s1 <= ZERO_VEC;
            r_s2 <= ZERO_VEC;
            r_s3 <= ZERO_VEC;
        end else begin
            r_s1 <= Button_In;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge = r_s2 & ~r_s3;

`ifdef DEBOUNCE_SCHEDULER_RELEASE_WAIT_EN
    assign w_release_ok = ~r_s2[r_grant_idx];
`else
    assign w_release_ok = 1'b1;
`endif

    // The channel being serviced ignores its own edges as bounce.
    always_comb begin
        w_lock = ZERO_VEC;
        if (r_state != ST_IDLE) begin
            w_lock = ONE_HOT0 << r_grant_idx;
        end else begin
            w_lock = ZERO_VEC;
        end
    end

    // Round-robin pick: first pending bit at or after Last_Grant+1, wrapping.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = {IDX_W{1'b0}};
        w_cand      = {IDX_W{1'b0}};
        w_hit       = 1'b0;
        for (int off = 1; off <= int'(NUM_BUTTONS); off++) begin
            w_cand      = IDX_W'((int'(r_last_grant) + off) % int'(NUM_BUTTONS));
            w_hit       = ~w_sel_found & r_pending[w_cand];
            w_sel_idx   = w_hit ? w_cand : w_sel_idx;
            w_sel_found = w_sel_found | w_hit;
        end
    end

    // Clear mask for the channel granted this cycle; it overrides a same-cycle set.
    always_comb begin
        w_grant_mask = ZERO_VEC;
        if ((r_state == ST_IDLE) && w_sel_found) begin
            w_grant_mask = ONE_HOT0 << w_sel_idx;
        end else begin
            w_grant_mask = ZERO_VEC;
        end
    end

    // Pending request queue.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_pending <= ZERO_VEC;
        end else begin
            r_pending <= (r_pending | (w_edge & ~w_lock)) & ~w_grant_mask;
        end
    end

    // Scheduler FSM: arbitrate, emit one pulse, then blank on the shared counter.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_pulse      <= ZERO_VEC;
            r_grant_idx  <= {IDX_W{1'b0}};
            r_last_grant <= LAST_IDX;
            r_busy       <= 1'b0;
            r_cnt        <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_found) begin
                        r_grant_idx  <= w_sel_idx;
                        r_last_grant <= w_sel_idx;
                        r_cnt        <= DEBOUNCE_LENGTH;
                        r_pulse      <= ONE_HOT0 << w_sel_idx;
                        r_busy       <= 1'b1;
                        r_state      <= ST_GRANT;
                    end else begin
                        r_pulse      <= ZERO_VEC;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    r_pulse <= ZERO_VEC;
                    r_busy  <= 1'b1;
                    r_state <= ST_BLANK;
                end
                ST_BLANK: begin
                    r_pulse <= ZERO_VEC;
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        if (w_release_ok) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= ST_BLANK;
                        end
                    end else begin
                        r_cnt   <= r_cnt - CNT_W'(1);
                        r_busy  <= 1'b1;
                        r_state <= ST_BLANK;
                    end
                end
                default: begin
                    r_pulse <= ZERO_VEC;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Button_Pulse = r_pulse;
    assign Grant_Index  = r_grant_idx;
    assign Busy         = r_busy;
    assign Pending      = r_pending;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Randomized self-checking bench for debounce_scheduler: two instances (reload 8 and 0)
// compared every cycle against a timestamp-based reference model.
module tb_debounce_scheduler;

    localparam int NB = 4;
    localparam int IW = 2;
    localparam int NU = 2;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn;
    logic [NB-1:0] pulse_a, pend_a, pulse_b, pend_b;
    logic [IW-1:0] gi_a, gi_b;
    logic          busy_a, busy_b;

    int n_checks;
    int n_errors;
    int cyc;

    logic [NB-1:0] m_pend  [NU];
    logic [NB-1:0] m_pulse [NU];
    int            m_gi    [NU];
    int            m_last  [NU];
    int            m_g     [NU];
    bit            m_act   [NU];
    logic [NB-1:0] samp    [$];

    debounce_scheduler #(.NUM_BUTTONS(NB), .CNT_W(22), .DEBOUNCE_LENGTH(22'd8)) u_dut_a (
        .CLK(clk), .Reset(rst), .Button_In(btn), .Button_Pulse(pulse_a),
        .Grant_Index(gi_a), .Busy(busy_a), .Pending(pend_a));

    debounce_scheduler #(.NUM_BUTTONS(NB), .CNT_W(22), .DEBOUNCE_LENGTH(22'd0)) u_dut_b (
        .CLK(clk), .Reset(rst), .Button_In(btn), .Button_Pulse(pulse_b),
        .Grant_Index(gi_b), .Busy(busy_b), .Pending(pend_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dl_of(input int u);
        return (u == 0) ? 8 : 0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference: a grant at edge g pulses once, is busy through g+DL+1, and frees at g+DL+2 or later.
    task automatic model_edge();
        logic [NB-1:0] e;
        logic [NB-1:0] lock;
        logic [NB-1:0] clr;
        logic [NB-1:0] s2v;
        bit            found;
        bit            rel_ok;
        int            c;
        if (rst) begin
            for (int u = 0; u < NU; u++) begin
                m_pend[u]  = 4'b0000;
                m_pulse[u] = 4'b0000;
                m_gi[u]    = 0;
                m_last[u]  = NB - 1;
                m_g[u]     = 0;
                m_act[u]   = 1'b0;
            end
            samp.delete();
            repeat (3) samp.push_back(4'b0000);
        end else begin
            e   = samp[1] & ~samp[2];
            s2v = samp[1];
            for (int u = 0; u < NU; u++) begin
                lock       = m_act[u] ? (4'b0001 << m_gi[u]) : 4'b0000;
                clr        = 4'b0000;
                m_pulse[u] = 4'b0000;
                found      = 1'b0;
                if (!m_act[u]) begin
                    for (int k = 1; k <= NB; k++) begin
                        c = (m_last[u] + k) % NB;
                        if (!found && m_pend[u][c]) begin
                            found      = 1'b1;
                            m_gi[u]    = c;
                            m_last[u]  = c;
                            m_g[u]     = cyc;
                            m_act[u]   = 1'b1;
                            m_pulse[u] = 4'b0001 << c;
                            clr        = 4'b0001 << c;
                        end
                    end
                end else begin
`ifdef DEBOUNCE_SCHEDULER_RELEASE_WAIT_EN
                    rel_ok = (s2v[m_gi[u]] == 1'b0);
`else
                    rel_ok = 1'b1;
`endif
                    if ((cyc >= m_g[u] + dl_of(u) + 2) && rel_ok) m_act[u] = 1'b0;
                end
                m_pend[u] = (m_pend[u] | (e & ~lock)) & ~clr;
            end
            samp.push_front(btn);
            void'(samp.pop_back());
        end
        cyc++;
    endtask

    task automatic compare_all();
        check_eq("pulse_a",   32'(pulse_a), 32'(m_pulse[0]));
        check_eq("pending_a", 32'(pend_a),  32'(m_pend[0]));
        check_eq("busy_a",    32'(busy_a),  32'(m_act[0]));
        check_eq("grant_a",   32'(gi_a),    32'(m_gi[0]));
        check_eq("pulse_b",   32'(pulse_b), 32'(m_pulse[1]));
        check_eq("pending_b", 32'(pend_b),  32'(m_pend[1]));
        check_eq("busy_b",    32'(busy_b),  32'(m_act[1]));
        check_eq("grant_b",   32'(gi_b),    32'(m_gi[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        logic [NB-1:0] flips;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst      = 1'b1;
        btn      = 4'b0000;
        repeat (3) samp.push_back(4'b0000);
        run(3);
        check_eq("reset_pulse", 32'(pulse_a), 32'd0);
        check_eq("reset_busy",  32'(busy_a),  32'd0);
        rst = 1'b0;

        // Clean long press on channel 1.
        btn = 4'b0010; run(30);
        btn = 4'b0000; run(20);

        // Bouncy press on channel 2.
        for (int i = 0; i < 5; i++) begin
            btn[2] = (i % 2 == 0);
            run(1);
        end
        run(20);
        btn = 4'b0000; run(20);

        // Simultaneous rise on channels 0 and 3.
        btn = 4'b1001; run(25);
        btn = 4'b0000; run(15);

        // Round robin: re-press 0 together with 1 while 0 is blanking.
        btn = 4'b0001; run(3);
        btn = 4'b0000; run(3);
        btn = 4'b0011; run(30);
        btn = 4'b0000; run(30);

        // Reset mid-blank with channel 3 pending, channel 3 held through reset.
        btn = 4'b0100; run(6);
        btn = 4'b1100; run(3);
        rst = 1'b1; btn = 4'b1000; run(2);
        rst = 1'b0; run(25);
        btn = 4'b0000; run(20);

        // Random chatter with occasional resets.
        for (int t = 0; t < 3000; t++) begin
            flips = 4'b0000;
            for (int b = 0; b < NB; b++) flips[b] = ($urandom_range(0, 5) == 0);
            btn = btn ^ flips;
            rst = ($urandom_range(0, 249) == 0);
            run(1);
        end
        rst = 1'b0;
        btn = 4'b0000;
        run(30);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
